// File: rtl/obi_uart_tx_pkg.sv
// Shared types and constants for the OBI UART transmitter.
// Define OBI_UART_TX_PARITY_EN to include the even-parity state (8E1 frames).
package obi_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef OBI_UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_e;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int unsigned STAT_FULL  = 0;
    localparam int unsigned STAT_EMPTY = 1;
    localparam int unsigned STAT_BUSY  = 2;
    localparam int unsigned STAT_OVF   = 3;

    localparam logic [15:0] MIN_DIV = 16'd4;

    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < MIN_DIV) ? MIN_DIV : v;
    endfunction

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/obi_uart_tx_fifo.sv
// Synchronous FIFO for the transmitter; pushes into a full FIFO are dropped.
module obi_uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == CW'(0));
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;

    // Pointer, occupancy and storage next-state.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s && !do_pop_s) begin
            count_d = count_q + CW'(1);
        end else if (do_pop_s && !do_push_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/obi_uart_tx.sv
// OBI-attached UART transmitter: register file, TX FIFO and 8N1 serializer.
// Define OBI_UART_TX_PARITY_EN for 8E1 frames (even parity bit after the data).
module obi_uart_tx
    import obi_uart_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DEFAULT_DIV = 868
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        tx_o,
    output logic        irq_o
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_e      state_q, state_d;
    logic [15:0] div_q, div_d, div_lat_q, div_lat_d, timer_q, timer_d, reload_s;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d, fifo_data_s;
    logic        tx_q, tx_d, tx_en_q, tx_en_d, irq_en_q, irq_en_d, ovf_q, ovf_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        push_s, pop_s, fifo_full_s, fifo_empty_s, busy_s, start_ok_s;
    logic [CW-1:0] fifo_count_s;
    logic        unused_s;

    assign unused_s = ^{addr_i[31:4], addr_i[1:0], be_i[3:2], wdata_i[31:16], fifo_count_s};

    obi_uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .data_i  (wdata_i[7:0]),
        .pop_i   (pop_s),
        .data_o  (fifo_data_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    assign gnt_o      = req_i;
    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;
    assign tx_o       = tx_q;
    assign busy_s     = (state_q != ST_IDLE);
    assign irq_o      = irq_en_q & fifo_empty_s & ~busy_s;
    assign start_ok_s = tx_en_q & ~fifo_empty_s;
    assign reload_s   = div_lat_q - 16'd1;

    // Register writes, read mux and the one-cycle OBI response.
    always_comb begin
        div_d    = div_q;
        tx_en_d  = tx_en_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;
        push_s   = 1'b0;
        rdata_d  = 32'h0000_0000;
        rvalid_d = req_i;
        if (req_i && we_i) begin
            case (addr_i[3:2])
                REG_TXDATA: begin
                    push_s = be_i[0];
                    ovf_d  = ovf_q | (be_i[0] & fifo_full_s);
                end
                REG_STATUS: ovf_d = ovf_q & ~(be_i[0] & wdata_i[STAT_OVF]);
                REG_DIV:    div_d = clamp_div({be_i[1] ? wdata_i[15:8] : div_q[15:8],
                                               be_i[0] ? wdata_i[7:0]  : div_q[7:0]});
                REG_CTRL: begin
                    if (be_i[0]) begin
                        tx_en_d  = wdata_i[0];
                        irq_en_d = wdata_i[1];
                    end else begin
                        tx_en_d  = tx_en_q;
                        irq_en_d = irq_en_q;
                    end
                end
                default: push_s = 1'b0;
            endcase
        end else if (req_i) begin
            case (addr_i[3:2])
                REG_STATUS: begin
                    rdata_d[STAT_FULL]  = fifo_full_s;
                    rdata_d[STAT_EMPTY] = fifo_empty_s;
                    rdata_d[STAT_BUSY]  = busy_s;
                    rdata_d[STAT_OVF]   = ovf_q;
                end
                REG_DIV:  rdata_d = {16'h0000, div_q};
                REG_CTRL: rdata_d = {30'h0000_0000, irq_en_q, tx_en_q};
                default:  rdata_d = 32'h0000_0000;
            endcase
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    // Serializer: the divisor is latched per frame so DIV writes only affect later frames.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        div_lat_d = div_lat_q;
        pop_s     = 1'b0;
        tx_d      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    pop_s     = 1'b1;
                    state_d   = ST_START;
                    shreg_d   = fifo_data_s;
                    div_lat_d = div_q;
                    timer_d   = div_q - 16'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (timer_q == 16'd0) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    timer_d = reload_s;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (timer_q != 16'd0) begin
                    timer_d = timer_q - 16'd1;
                end else if (bit_q == 3'd7) begin
`ifdef OBI_UART_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                    timer_d = reload_s;
                end else begin
                    bit_d   = bit_q + 3'd1;
                    timer_d = reload_s;
                end
            end
`ifdef OBI_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (timer_q == 16'd0) begin
                    state_d = ST_STOP;
                    timer_d = reload_s;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (timer_q != 16'd0) begin
                    timer_d = timer_q - 16'd1;
                end else if (start_ok_s) begin
                    pop_s     = 1'b1;
                    state_d   = ST_START;
                    shreg_d   = fifo_data_s;
                    div_lat_d = div_q;
                    timer_d   = div_q - 16'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Line level is registered from the next state so tx_o never glitches.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[bit_d];
`ifdef OBI_UART_TX_PARITY_EN
            ST_PARITY: tx_d = even_parity(shreg_d);
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            timer_q   <= 16'd0;
            bit_q     <= 3'd0;
            shreg_q   <= 8'd0;
            div_lat_q <= 16'(DEFAULT_DIV);
            div_q     <= 16'(DEFAULT_DIV);
            tx_q      <= 1'b1;
            tx_en_q   <= 1'b1;
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            div_lat_q <= div_lat_d;
            div_q     <= div_d;
            tx_q      <= tx_d;
            tx_en_q   <= tx_en_d;
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_obi_uart_tx.sv
// Self-checking bench for obi_uart_tx: directed register checks plus random frames
// compared against a frame-level model (start, LSB-first data, optional parity, stop).
module tb_obi_uart_tx;
    logic        clk_i = 1'b0;
    logic        rst_i, req_i, we_i;
    logic [31:0] addr_i, wdata_i;
    logic [3:0]  be_i;
    logic        gnt_o, rvalid_o, tx_o, irq_o;
    logic [31:0] rdata_o;

    always #5 clk_i = ~clk_i;

    obi_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(868)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
        .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .tx_o(tx_o), .irq_o(irq_o)
    );

`ifdef OBI_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    int n_checks = 0;
    int n_err    = 0;
    logic [7:0] model_q[$];

    function automatic logic [255:0] exp_frame(input logic [7:0] b, input int div);
        logic [255:0] v;
        logic bitv;
        v = '0;
        for (int p = 0; p < NBITS; p++) begin
            if (p == 0) bitv = 1'b0;
            else if (p <= 8) bitv = b[p-1];
            else if (p == 9 && NBITS == 11) bitv = ^b;
            else bitv = 1'b1;
            for (int c = 0; c < div; c++) v[p*div + c] = bitv;
        end
        return v;
    endfunction

    function automatic logic [255:0] ones(input int n);
        return (256'd1 << n) - 256'd1;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [1:0] ra, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd);
        req_i = 1'b1; we_i = we; addr_i = {28'h0, ra, 2'b00}; be_i = be; wdata_i = wd;
        #1;
        chk("gnt", gnt_o, 1);
        @(posedge clk_i);
        #1;
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
        chk("rvalid", rvalid_o, 1);
        rd = rdata_o;
        if (we) chk("wr_rdata", rd, 0);
    endtask

    task automatic wr(input logic [1:0] ra, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] d;
        bus(1'b1, ra, be, wd, d);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] ra, input logic [31:0] exp);
        logic [31:0] d;
        bus(1'b0, ra, 4'hF, 32'h0, d);
        chk(tag, d, exp);
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr(2'd0, 4'h1, {24'h0, b});
        if (model_q.size() < 8) model_q.push_back(b);
    endtask

    task automatic capture(input int n, output logic [255:0] txv, output logic [255:0] irqv);
        txv = '0;
        irqv = '0;
        for (int i = 0; i < n; i++) begin
            txv[i] = tx_o;
            irqv[i] = irq_o;
            tick();
        end
    endtask

    initial begin
        logic [255:0] txv, irqv;
        logic [7:0]   b;
        int           div;

        rst_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
        repeat (3) tick();
        chk("rst_gnt_hi", gnt_o, 1);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_tx", tx_o, 1);
        chk("rst_irq", irq_o, 0);
        req_i = 1'b0;
        #1;
        chk("rst_gnt_lo", gnt_o, 0);
        rst_i = 1'b0;
        tick();

        rd_chk("rst_status", 2'd1, 32'h2);
        rd_chk("rst_div", 2'd2, 32'd868);
        rd_chk("rst_ctrl", 2'd3, 32'h1);
        rd_chk("txdata_read", 2'd0, 32'h0);
        tick();
        chk("rvalid_idle", rvalid_o, 0);
        chk("rdata_idle", rdata_o, 0);

        // Directed 0xA5 frame at DIV=4.
        wr(2'd2, 4'h3, 32'd4);
        push_byte(8'hA5);
        chk("irq_disabled", irq_o, 0);
        tick();
        capture(NBITS * 4, txv, irqv);
        chk("frame_a5", txv, exp_frame(model_q.pop_front(), 4));
        chk("idle_after_a5", tx_o, 1);
        rd_chk("status_idle", 2'd1, 32'h2);

        // Random bytes at random divisors.
        for (int k = 0; k < 4; k++) begin
            div = $urandom_range(12, 4);
            b = 8'($urandom);
            wr(2'd2, 4'h3, div);
            push_byte(b);
            tick();
            capture(NBITS * div, txv, irqv);
            chk("frame_rand", txv, exp_frame(model_q.pop_front(), div));
        end

        // Divisor clamp and per-byte enables.
        wr(2'd2, 4'h3, $urandom_range(3, 0));
        rd_chk("div_clamp", 2'd2, 32'd4);
        wr(2'd2, 4'h1, 32'hABCD_0009);
        rd_chk("div_be0", 2'd2, 32'h9);
        wr(2'd2, 4'h2, 32'h0000_0300);
        rd_chk("div_be1", 2'd2, 32'h309);
        wr(2'd2, 4'h3, 32'd4);

        // Fill with tx disabled, overflow, clear, then drain back-to-back.
        wr(2'd3, 4'h1, 32'h0);
        for (int k = 0; k < 9; k++) push_byte(8'($urandom));
        rd_chk("full_ovf", 2'd1, 32'h9);
        wr(2'd1, 4'h1, 32'h8);
        rd_chk("ovf_clear", 2'd1, 32'h1);
        wr(2'd3, 4'h1, 32'h1);
        tick();
        for (int k = 0; k < 8; k++) begin
            capture(NBITS * 4, txv, irqv);
            chk("frame_b2b", txv, exp_frame(model_q.pop_front(), 4));
        end
        chk("idle_after_b2b", tx_o, 1);
        rd_chk("status_drained", 2'd1, 32'h2);

        // tx_en cleared mid-frame: frame completes, second byte is held.
        wr(2'd3, 4'h1, 32'h0);
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        wr(2'd3, 4'h1, 32'h1);
        wr(2'd3, 4'h1, 32'h0);
        capture(NBITS * 4, txv, irqv);
        chk("frame_txen_off", txv, exp_frame(model_q.pop_front(), 4));
        capture(2 * NBITS * 4, txv, irqv);
        chk("hold_txen_off", txv, ones(2 * NBITS * 4));
        rd_chk("status_held", 2'd1, 32'h0);
        wr(2'd3, 4'h1, 32'h1);
        tick();
        capture(NBITS * 4, txv, irqv);
        chk("frame_resume", txv, exp_frame(model_q.pop_front(), 4));

        // DIV written mid-frame applies from the next frame.
        push_byte(8'($urandom));
        wr(2'd2, 4'h3, 32'd6);
        capture(NBITS * 4, txv, irqv);
        chk("frame_old_div", txv, exp_frame(model_q.pop_front(), 4));
        push_byte(8'($urandom));
        tick();
        capture(NBITS * 6, txv, irqv);
        chk("frame_new_div", txv, exp_frame(model_q.pop_front(), 6));

        // Interrupt: high while idle and empty, low from push to end of STOP.
        wr(2'd2, 4'h3, 32'd2);
        rd_chk("div_two_clamp", 2'd2, 32'd4);
        wr(2'd3, 4'h1, 32'h3);
        tick();
        chk("irq_idle", irq_o, 1);
        push_byte(8'($urandom));
        chk("irq_after_push", irq_o, 0);
        tick();
        capture(NBITS * 4, txv, irqv);
        chk("frame_irq", txv, exp_frame(model_q.pop_front(), 4));
        chk("irq_during_frame", irqv, 0);
        chk("irq_after_frame", irq_o, 1);

        // Reset in the middle of DATA.
        wr(2'd3, 4'h1, 32'h1);
        push_byte(8'h00);
        push_byte(8'h00);
        rd_chk("status_busy", 2'd1, 32'h4);
        repeat (6) tick();
        chk("pre_rst_tx", tx_o, 0);
        rst_i = 1'b1;
        #1;
        chk("rst_mid_tx", tx_o, 1);
        model_q.delete();
        tick();
        rst_i = 1'b0;
        tick();
        rd_chk("post_rst_status", 2'd1, 32'h2);
        rd_chk("post_rst_div", 2'd2, 32'd868);
        rd_chk("post_rst_ctrl", 2'd3, 32'h1);
        capture(20, txv, irqv);
        chk("no_residual", txv, ones(20));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
